// File: rtl/reg_wr_arbiter.sv
// Write-port arbiter for the CPU register bank: round-robin over NREQ requesters,
// registered grant/write port and a wrapping write counter. Define REG_WR_FIXED_PRIO_EN for fixed priority.
module reg_wr_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 3,
    parameter int DW   = 16,
    parameter int CW   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic               wr_en,
    output logic [AW-1:0]      wr_addr,
    output logic [DW-1:0]      wr_data,
    output logic [CW-1:0]      wr_count
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [NREQ-1:0] elig_p0;
    logic [NREQ-1:0] win_oh_p0;
    logic [PW-1:0]   win_idx_p0;
    logic            found_p0;
    logic [AW-1:0]   win_addr_p0;
    logic [DW-1:0]   win_data_p0;
`ifndef REG_WR_FIXED_PRIO_EN
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt_p0;
    int              idx;
`endif

    // Stage p0: pick the winner among eligible requesters (holder is masked out)
    always_comb begin
        elig_p0    = req & ~gnt;
        found_p0   = 1'b0;
        win_idx_p0 = '0;
`ifdef REG_WR_FIXED_PRIO_EN
        for (int k = 0; k < NREQ; k++) begin
            if (!found_p0 && elig_p0[k]) begin
                found_p0   = 1'b1;
                win_idx_p0 = PW'(k);
            end
        end
`else
        idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found_p0 && elig_p0[idx]) begin
                found_p0   = 1'b1;
                win_idx_p0 = PW'(idx);
            end
        end
        ptr_nxt_p0 = (int'(win_idx_p0) == NREQ - 1) ? '0 : win_idx_p0 + PW'(1);
`endif
        win_oh_p0   = found_p0 ? (NREQ'(1) << win_idx_p0) : '0;
        win_addr_p0 = req_addr[int'(win_idx_p0)*AW +: AW];
        win_data_p0 = req_data[int'(win_idx_p0)*DW +: DW];
    end

    // Stage p1: registered grant and write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_count <= '0;
`ifndef REG_WR_FIXED_PRIO_EN
            ptr      <= '0;
`endif
        end else begin
            case (state)
                IDLE:    state <= found_p0 ? GRANT : IDLE;
                GRANT:   state <= found_p0 ? GRANT : IDLE;
                default: state <= IDLE;
            endcase
            gnt   <= win_oh_p0;
            wr_en <= found_p0;
            if (found_p0) begin
                wr_addr  <= win_addr_p0;
                wr_data  <= win_data_p0;
                wr_count <= wr_count + CW'(1);
`ifndef REG_WR_FIXED_PRIO_EN
                ptr      <= ptr_nxt_p0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed bench for reg_wr_arbiter (NREQ=4, AW=3, DW=16, CW=4 so the counter wrap is reachable).
module tb_reg_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] req_addr;
    logic [63:0] req_data;
    logic [3:0]  gnt;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  wr_count;

    int total = 0;
    int bad   = 0;

    reg_wr_arbiter #(.NREQ(4), .AW(3), .DW(16), .CW(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0]  expg [5];
        logic [15:0] expd [5];
        logic [2:0]  expa [5];
        logic [3:0]  exp_cnt;

        rst      = 1'b1;
        req      = 4'b0000;
        // addr: r0=2 r1=3 r2=5 r3=7; data: r0=1111 r1=A5A5 r2=3333 r3=4444
        req_addr = {3'd7, 3'd5, 3'd3, 3'd2};
        req_data = {16'h4444, 16'h3333, 16'hA5A5, 16'h1111};
        #12;
        chk("rst_gnt", gnt, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_wr_count", wr_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset during the second grant aborts it
        req = 4'b0011;
        tick();
        chk("a_gnt0", gnt, 4'b0001);
        chk("a_cnt0", wr_count, 1);
        tick();
        chk("a_gnt1", gnt, 4'b0010);
        chk("a_data1", wr_data, 16'hA5A5);
        chk("a_cnt1", wr_count, 2);
        #2 rst = 1'b1;
        #1;
        chk("a_async_gnt", gnt, 0);
        chk("a_async_wr_en", wr_en, 0);
        chk("a_async_cnt", wr_count, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("a_post_gnt", gnt, 4'b0001);
        chk("a_post_addr", wr_addr, 2);
        chk("a_post_cnt", wr_count, 1);
        req = 4'b0000;
        tick();
        chk("a_idle_gnt", gnt, 0);
        chk("a_idle_wr_en", wr_en, 0);
        chk("a_hold_addr", wr_addr, 2);
        chk("a_hold_data", wr_data, 16'h1111);

        // Lone requester 1 is granted every other cycle
        req = 4'b0010;
        tick();
        chk("b_gnt0", gnt, 4'b0010);
        chk("b_addr0", wr_addr, 3);
        chk("b_data0", wr_data, 16'hA5A5);
        chk("b_cnt0", wr_count, 2);
        tick();
        chk("b_gnt1", gnt, 0);
        chk("b_wr_en1", wr_en, 0);
        tick();
        chk("b_gnt2", gnt, 4'b0010);
        chk("b_wr_en2", wr_en, 1);
        chk("b_cnt2", wr_count, 3);
        req = 4'b0000;
        tick();
        chk("b_gnt3", gnt, 0);

        // All requesting: back-to-back grants, ptr starts at 2 in round-robin
`ifdef REG_WR_FIXED_PRIO_EN
        expg[0] = 4'b0001; expg[1] = 4'b0010; expg[2] = 4'b0001; expg[3] = 4'b0010; expg[4] = 4'b0001;
        expd[0] = 16'h1111; expd[1] = 16'hA5A5; expd[2] = 16'h1111; expd[3] = 16'hA5A5; expd[4] = 16'h1111;
        expa[0] = 3'd2; expa[1] = 3'd3; expa[2] = 3'd2; expa[3] = 3'd3; expa[4] = 3'd2;
`else
        expg[0] = 4'b0100; expg[1] = 4'b1000; expg[2] = 4'b0001; expg[3] = 4'b0010; expg[4] = 4'b0100;
        expd[0] = 16'h3333; expd[1] = 16'h4444; expd[2] = 16'h1111; expd[3] = 16'hA5A5; expd[4] = 16'h3333;
        expa[0] = 3'd5; expa[1] = 3'd7; expa[2] = 3'd2; expa[3] = 3'd3; expa[4] = 3'd5;
`endif
        req = 4'b1111;
        exp_cnt = 4'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_cnt = exp_cnt + 4'd1;
            chk($sformatf("c_gnt%0d", i), gnt, expg[i]);
            chk($sformatf("c_data%0d", i), wr_data, expd[i]);
            chk($sformatf("c_addr%0d", i), wr_addr, expa[i]);
            chk($sformatf("c_cnt%0d", i), wr_count, exp_cnt);
        end
        req = 4'b0000;
        tick();
        chk("c_idle", gnt, 0);

        // Requester 0 wins, then 0101 goes to 2 before 0
        req = 4'b0001;
        tick();
        chk("d_gnt0", gnt, 4'b0001);
        req = 4'b0101;
        tick();
        chk("d_gnt1", gnt, 4'b0100);
        chk("d_data1", wr_data, 16'h3333);
        tick();
        chk("d_gnt2", gnt, 4'b0001);
        chk("d_cnt2", wr_count, 11);
        req = 4'b0000;
        tick();
        chk("d_idle", gnt, 0);

        // Counter wraps 15 -> 0 -> 1
        req = 4'b0001;
        exp_cnt = 4'd11;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i % 2 == 1) begin
                exp_cnt = exp_cnt + 4'd1;
                chk($sformatf("e_gnt%0d", i), gnt, 4'b0001);
            end else begin
                chk($sformatf("e_gnt%0d", i), gnt, 0);
            end
            chk($sformatf("e_cnt%0d", i), wr_count, exp_cnt);
        end
        chk("e_final_cnt", wr_count, 1);
        req = 4'b0000;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
